// File: rtl/booth_pp_accum.sv
// booth_pp_accum
// Consumer end of the radix-4 Booth partial-product interface. Accepts one
// complete set of Booth partial products, latches it, and sums it into the
// 64-bit product over several cycles. Only one multiplication is in flight.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   resetn     asynchronous active-low reset
//   in_valid   a partial-product set is presented
//   in_ready   block can accept a set (IDLE only, low while in reset)
//   pp_bus     16 x 34-bit Booth digit terms, pp_k at [34k+33:34k]
//   neg        negate-completion bits, neg[k] adds +1 at weight 4^k
//   pp16       unsigned correction term, added at weight 2^32
//   out_valid  product valid, held until accepted
//   out_ready  downstream accepts the product
//   product    64-bit result
//
// Parameter:
//   PP_PER_CYCLE  partial products summed per ACC cycle (1, 2, 4, 8 or 16)

module booth_pp_accum #(
  parameter int PP_PER_CYCLE = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [543:0] pp_bus,
  input  logic [15:0]  neg,
  input  logic [31:0]  pp16,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  product
);

  localparam int         ACC_CYCLES = 16 / PP_PER_CYCLE;
  localparam logic [4:0] LAST_CNT   = 5'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [543:0]  pp_q, pp_d;
  logic [15:0]   neg_q, neg_d;
  logic [31:0]   pp16_q, pp16_d;
  logic [63:0]   acc_q, acc_d;
  logic [63:0]   product_q, product_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;

  logic [33:0]   pp_arr [16];
  logic [63:0]   grp_sum;
  logic [63:0]   neg_term;
  logic [3:0]    k_idx;

  // Unpack the latched bus into individual 34-bit digit terms.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      pp_arr[i] = pp_q[i*34 +: 34];
    end
  end

  // Sum of the current group of PP_PER_CYCLE terms. Each term is sign
  // extended to 64 bits and placed at weight 4^k; the counter never exceeds
  // ACC_CYCLES-1 so the truncated index stays within 0..15.
  always_comb begin
    grp_sum = '0;
    k_idx   = '0;
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      k_idx   = 4'(int'(cnt_q) * PP_PER_CYCLE + j);
      grp_sum = grp_sum + ({{30{pp_arr[k_idx][33]}}, pp_arr[k_idx]} << {k_idx, 1'b0});
    end
  end

  // Negate-completion vector: neg[k] lands on bit 2k, odd bits stay zero.
  always_comb begin
    neg_term = '0;
    for (int i = 0; i < 16; i++) begin
      neg_term[2*i] = neg_q[i];
    end
  end

  // Next-state and datapath update for the IDLE/ACC/FIN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    pp_d        = pp_q;
    neg_d       = neg_q;
    pp16_d      = pp16_q;
    acc_d       = acc_q;
    product_d   = product_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          pp_d    = pp_bus;
          neg_d   = neg;
          pp16_d  = pp16;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end

      ACC: begin
        acc_d = acc_q + grp_sum;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = FIN;
        end
      end

      // Fold in the negate completions and the unsigned correction, then
      // publish the result.
      FIN: begin
        product_d   = acc_q + neg_term + {pp16_q, 32'b0};
        acc_d       = product_d;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any in-flight set entirely.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pp_q        <= '0;
      neg_q       <= '0;
      pp16_q      <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pp_q        <= pp_d;
      neg_q       <= neg_d;
      pp16_q      <= pp16_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // in_ready is gated by resetn so it reads low while reset is asserted.
  assign in_ready  = (state_q == IDLE) && resetn;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: doc/booth_pp_accum.md
Name: booth_pp_accum

Overview:
- Consumer end of the radix-4 Booth partial-product interface: accepts one full set of Booth partial products (16 x 34-bit digit terms, 16 negate-completion bits, 32-bit unsigned correction term) and sums them iteratively into the 64-bit product.
- Sits between the Booth partial-product generator and the multiplier result register / writeback.
- Valid/ready on both sides; one multiplication in flight.

Parameters:
- PP_PER_CYCLE, 2, partial products added per ACC cycle; legal values 1, 2, 4, 8, 16.
- ACC_CYCLES, 16/PP_PER_CYCLE, derived, not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  a partial-product set is presented.
- in_ready  output  1  block can accept a set; high only in IDLE.
- pp_bus  input  544  pp_k at bits [34k+33:34k], k=0..15; each is a 34-bit two's-complement Booth digit x A, in one's-complement form for negative digits.
- neg  input  16  neg[k]=1 adds +1 at weight 4^k, completing the negation of pp_k.
- pp16  input  32  unsigned correction term, added at weight 2^32.
- out_valid  output  1  product valid; held until accepted.
- out_ready  input  1  downstream accepts the product.
- product  output  64  result.

Behaviour:
- Product definition, all mod 2^64: sum over k of sext64(pp_k)<<2k, plus sum over k of neg[k]<<2k, plus zext64(pp16)<<32.
  - The neg term is a 32-bit value with neg[k] at bit 2k and zeros at odd bits.
- States: IDLE, ACC, FIN, DONE.
- Reset (asynchronous, resetn low):
  - State goes to IDLE; in_ready=0 while resetn is low.
  - out_valid=0, product=0, accumulator=0, group counter=0.
  - Input latches are cleared.
- Reset mid-operation: the in-flight operation is discarded. There is no output for it, and no partial state survives.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch pp_bus, neg and pp16; clear the accumulator and counter; go to ACC.
  - Inputs may change freely after the accept edge.
- ACC:
  - Each edge adds the PP_PER_CYCLE terms with k = cnt*PP_PER_CYCLE .. cnt*PP_PER_CYCLE+PP_PER_CYCLE-1, then increments cnt.
  - After ACC_CYCLES edges, go to FIN.
- FIN: one edge; adds the neg vector term and pp16<<32, loads product, sets out_valid=1, goes to DONE.
- DONE:
  - product and out_valid are stable.
  - On out_valid&out_ready: clear out_valid and go to IDLE.
  - product keeps its last value until the next FIN.
- Latency: out_valid rises ACC_CYCLES+1 edges after the accept edge (9 at default).
- Throughput: one set per ACC_CYCLES+3 cycles when out_ready is held high.
- in_ready=0 in ACC, FIN and DONE. in_valid in those states is ignored and does not corrupt the latched set.
- out_ready asserted outside DONE has no effect.
- Overflow beyond bit 63 wraps silently; there is no flag.
- Fully deterministic: identical inputs always give identical cycle timing.

Test Plan:
- Simple positive term: pp0=7, all other pp=0, neg=0, pp16=0 -> product=64'h7; out_valid rises 9 edges after accept.
- Negate completion: pp0=34'h3_FFFF_FFF8, neg[0]=1, pp1=34'h7, rest 0 -> product=64'd21 (7x3).
- Unsigned correction: pp15=34'h3_FFFF_FFFD, neg[15]=1, pp16=32'h1, rest 0 -> product=64'h0000_0000_8000_0000 (1 x 0x80000000 unsigned).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0; in_valid pulsed during ACC is ignored and the result is unchanged.
- Reset mid-ACC: drop resetn at ACC cycle 3 -> out_valid=0 and product=0 immediately; after release, in_ready=1 and a fresh set computes correctly.
- Randomized: 1000 random a/b pairs, signed and unsigned, pp sets produced by the bench's Booth model -> product equals a*b (64-bit) for PP_PER_CYCLE=1, 2 and 16, with latencies 17, 9 and 2 edges.
